proc_gen: RTL and testbench



---
 rtl/proc_gen_pkg.sv | 39 +++
 rtl/proc_gen_regn.sv | 27 ++
 rtl/proc_gen.sv | 133 +++++++++++++
 tb/tb_proc_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/proc_gen_pkg.sv
// Shared definitions for proc_gen: opcodes, step encodings and instruction-field helpers.
package proc_gen_pkg;

    localparam int unsigned MAX_N  = 64;
    localparam int unsigned MAX_RW = 8;

    typedef enum logic [2:0] {
        OP_MV   = 3'b000,
        OP_MVI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_XOR  = 3'b101,
        OP_MVNZ = 3'b110,
        OP_NOP  = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_e;

    function automatic logic [2:0] get_op(input logic [MAX_N-1:0] ir, input int unsigned n);
        return 3'(ir >> (n - 3));
    endfunction

    function automatic logic [MAX_RW-1:0] get_x(input logic [MAX_N-1:0] ir,
                                                input int unsigned n, input int unsigned rw);
        return MAX_RW'((ir >> (n - 3 - rw)) & ((MAX_N'(1) << rw) - MAX_N'(1)));
    endfunction

    function automatic logic [MAX_RW-1:0] get_y(input logic [MAX_N-1:0] ir,
                                                input int unsigned n, input int unsigned rw);
        return MAX_RW'((ir >> (n - 3 - 2 * rw)) & ((MAX_N'(1) << rw) - MAX_N'(1)));
    endfunction

endpackage

// File: rtl/proc_gen_regn.sv
// N-bit register with load enable and asynchronous active-high clear.
module regn #(
    parameter int unsigned N = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) q_d = d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/proc_gen.sv
// Multi-cycle shared-bus processor: one instruction per Run, Done in its final step.
module proc_gen
    import proc_gen_pkg::*;
#(
    parameter int unsigned N    = 9,
    parameter int unsigned NREG = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Run,
    input  logic [N-1:0] DIN,
    output logic         Done,
    output logic [N-1:0] BusWires
);

    localparam int unsigned RW = $clog2(NREG);

    step_e             step_q, step_d;
    logic [N-1:0]      ir_q, a_q, g_q, alu_c;
    logic [N-1:0]      r_q [NREG];
    logic [NREG-1:0]   r_in, r_out, x_oh, y_oh;
    logic              ir_in, a_in, g_in, g_out, din_out;
    logic [NREG+1:0]   sel;
    opcode_e           op;
    logic [RW-1:0]     x_idx, y_idx;

    assign op    = opcode_e'(get_op(MAX_N'(ir_q), N));
    assign x_idx = RW'(get_x(MAX_N'(ir_q), N, RW));
    assign y_idx = RW'(get_y(MAX_N'(ir_q), N, RW));
    assign x_oh  = NREG'(1) << x_idx;
    assign y_oh  = NREG'(1) << y_idx;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) step_q <= T0;
        else       step_q <= step_d;
    end

    // Control decode: bus source, register loads and step sequencing.
    always_comb begin
        step_d  = step_q;
        Done    = 1'b0;
        ir_in   = 1'b0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        g_out   = 1'b0;
        din_out = 1'b0;
        r_in    = '0;
        r_out   = '0;
        case (step_q)
            T0: begin
                if (Run) begin
                    ir_in  = 1'b1;
                    step_d = T1;
                end
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        r_out  = y_oh;
                        r_in   = x_oh;
                        Done   = 1'b1;
                        step_d = T0;
                    end
                    OP_MVNZ: begin
                        r_out  = y_oh;
                        if (g_q != '0) r_in = x_oh;
                        Done   = 1'b1;
                        step_d = T0;
                    end
                    OP_MVI: begin
                        din_out = 1'b1;
                        r_in    = x_oh;
                        Done    = 1'b1;
                        step_d  = T0;
                    end
                    OP_NOP: begin
                        Done   = 1'b1;
                        step_d = T0;
                    end
                    default: begin
                        r_out  = x_oh;
                        a_in   = 1'b1;
                        step_d = T2;
                    end
                endcase
            end
            T2: begin
                r_out  = y_oh;
                g_in   = 1'b1;
                step_d = T3;
            end
            default: begin
                g_out  = 1'b1;
                r_in   = x_oh;
                Done   = 1'b1;
                step_d = T0;
            end
        endcase
    end

    always_comb begin
        case (op)
            OP_ADD:  alu_c = a_q + BusWires;
            OP_SUB:  alu_c = a_q - BusWires;
            OP_AND:  alu_c = a_q & BusWires;
            OP_XOR:  alu_c = a_q ^ BusWires;
            default: alu_c = '0;
        endcase
    end

    // Bus driven only when exactly one source is selected.
    assign sel = {din_out, g_out, r_out};

    always_comb begin
        BusWires = '0;
        if ($onehot(sel)) begin
            if (din_out) BusWires = DIN;
            if (g_out)   BusWires = g_q;
            for (int unsigned k = 0; k < NREG; k++) begin
                if (r_out[k]) BusWires = r_q[k];
            end
        end
    end

    regn #(.N(N)) u_ir (.clk(Clock), .rst(Reset), .en(ir_in), .d(DIN),      .q(ir_q));
    regn #(.N(N)) u_a  (.clk(Clock), .rst(Reset), .en(a_in),  .d(BusWires), .q(a_q));
    regn #(.N(N)) u_g  (.clk(Clock), .rst(Reset), .en(g_in),  .d(alu_c),    .q(g_q));

    for (genvar k = 0; k < NREG; k++) begin : g_reg
        regn #(.N(N)) u_r (.clk(Clock), .rst(Reset), .en(r_in[k]), .d(BusWires), .q(r_q[k]));
    end

endmodule

// File: tb/tb_proc_gen.sv
// Randomised scoreboard bench for proc_gen (N=9, NREG=8) observing BusWires and Done.
module tb_proc_gen;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Run;
    logic [8:0] DIN;
    logic       Done;
    logic [8:0] BusWires;

    typedef struct {
        logic [8:0] bus;
        logic       done;
    } exp_t;

    exp_t       exp_q [$];
    logic [8:0] regs [8];
    logic [8:0] g_m;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc_no   = 0;

    proc_gen #(.N(9), .NREG(8)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Run      (Run),
        .DIN      (DIN),
        .Done     (Done),
        .BusWires (BusWires)
    );

    always #5 Clock = ~Clock;

    // Monitor: compare the DUT outputs against the expectation queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            cyc_no++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (BusWires !== e.bus) begin
                    n_fail++;
                    $display("FAIL bus cycle %0d: got %h expected %h", cyc_no, BusWires, e.bus);
                end
                n_checks++;
                if (Done !== e.done) begin
                    n_fail++;
                    $display("FAIL done cycle %0d: got %b expected %b", cyc_no, Done, e.done);
                end
            end
        end
    end

    task automatic cyc(input logic rst, input logic run, input logic [8:0] din,
                       input logic [8:0] eb, input logic ed);
        exp_t e;
        @(posedge Clock);
        #1;
        Reset = rst;
        Run   = run;
        DIN   = din;
        e.bus  = eb;
        e.done = ed;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) regs[k] = '0;
        g_m = '0;
    endtask

    // Reference model: one instruction, queueing the bus/Done value for every cycle it takes.
    task automatic exec(input logic [8:0] instr, input logic [8:0] imm);
        logic [2:0] op;
        int         x, y;
        logic [8:0] rx, ry, res;
        op = instr[8:6];
        x  = int'(instr[5:3]);
        y  = int'(instr[2:0]);
        rx = regs[x];
        ry = regs[y];
        cyc(1'b0, 1'b1, instr, 9'h000, 1'b0);
        case (op)
            3'd0: begin
                cyc(1'b0, 1'($urandom), 9'($urandom), ry, 1'b1);
                regs[x] = ry;
            end
            3'd1: begin
                cyc(1'b0, 1'($urandom), imm, imm, 1'b1);
                regs[x] = imm;
            end
            3'd6: begin
                cyc(1'b0, 1'($urandom), 9'($urandom), ry, 1'b1);
                if (g_m != 0) regs[x] = ry;
            end
            3'd7: begin
                cyc(1'b0, 1'($urandom), 9'($urandom), 9'h000, 1'b1);
            end
            default: begin
                case (op)
                    3'd2:    res = 9'((int'(rx) + int'(ry)) % 512);
                    3'd3:    res = 9'((int'(rx) - int'(ry) + 512) % 512);
                    3'd4:    res = rx & ry;
                    default: res = rx ^ ry;
                endcase
                cyc(1'b0, 1'($urandom), 9'($urandom), rx, 1'b0);
                cyc(1'b0, 1'($urandom), 9'($urandom), ry, 1'b0);
                cyc(1'b0, 1'($urandom), 9'($urandom), res, 1'b1);
                g_m     = res;
                regs[x] = res;
            end
        endcase
    endtask

    task automatic mvi(input int x, input logic [8:0] v);
        exec({3'b001, 3'(x), 3'b000}, v);
    endtask

    task automatic readback();
        for (int k = 0; k < 8; k++) exec({3'b000, 3'(k), 3'(k)}, 9'h000);
    endtask

    initial begin
        Reset = 1'b1;
        Run   = 1'b0;
        DIN   = '0;
        model_reset();
        cyc(1'b1, 1'b0, 9'h000, 9'h000, 1'b0);
        cyc(1'b1, 1'b1, 9'h040, 9'h000, 1'b0);
        readback();

        // Idle in T0 with an instruction on DIN.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 9'h040, 9'h000, 1'b0);

        exec(9'h040, 9'd5);
        exec(9'h090, 9'h000);
        exec(9'h048, 9'd7);
        exec(9'h081, 9'h000);
        exec(9'h0C1, 9'h000);
        mvi(0, 9'd3);
        exec(9'h0C0, 9'h000);
        exec(9'h180, 9'h000);
        exec(9'h1D8, 9'h000);
        mvi(0, 9'd2);
        exec(9'h081, 9'h000);
        exec(9'h180, 9'h000);
        exec(9'h1C0, 9'h000);
        readback();

        mvi(0, 9'h1FF);
        mvi(1, 9'd1);
        exec(9'h081, 9'h000);
        mvi(0, 9'h155);
        mvi(1, 9'h0FF);
        exec(9'h141, 9'h000);
        exec(9'h101, 9'h000);
        readback();

        // Reset asserted during T2 of an add.
        mvi(0, 9'd4);
        mvi(1, 9'd6);
        cyc(1'b0, 1'b1, 9'h081, 9'h000, 1'b0);
        cyc(1'b0, 1'b0, 9'h000, regs[0], 1'b0);
        cyc(1'b1, 1'b1, 9'h000, 9'h000, 1'b0);
        model_reset();
        readback();
        exec(9'h0C1, 9'h000);
        exec(9'h180, 9'h000);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) cyc(1'b0, 1'b0, 9'($urandom), 9'h000, 1'b0);
            exec(9'($urandom), 9'($urandom));
        end
        readback();

        @(negedge Clock);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
